// File: rtl/bf_fetch_if.sv
// Fetch-unit bus: program ROM port plus the instruction handshake to the
// execute stage and the sticky status flags. master = fetch unit side.
interface bf_fetch_if #(
    parameter int ADDR_WIDTH = 4
) ();
    logic [ADDR_WIDTH-1:0] romAddr;
    logic [7:0]            romData;
    logic [7:0]            instr;
    logic                  instrValid;
    logic                  instrReady;
    logic                  cellZero;
    logic                  halted;
    logic                  error;

    modport master (
        output romAddr,
        input  romData,
        output instr,
        output instrValid,
        input  instrReady,
        input  cellZero,
        output halted,
        output error
    );

    modport slave (
        input  romAddr,
        output romData,
        input  instr,
        output instrValid,
        output instrReady,
        output cellZero,
        input  halted,
        input  error
    );
endinterface

// File: rtl/bf_fetch_unit.sv
// Brainfuck instruction fetch / jump unit.
// Fetches bytes from a registered-output program ROM, presents them over a
// valid/ready handshake and resolves '[' / ']' jumps by scanning the ROM
// with a nesting-depth counter.
// Optional build macro BF_FETCH_COMMENT_SKIP_EN: non-command bytes are
// skipped in the fetch path instead of being presented to the core.
module bf_fetch_unit #(
    parameter int ADDR_WIDTH  = 4,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    bf_fetch_if.master  bus
);
    typedef enum logic [2:0] {
        ISSUE,
        WAIT,
        VALID,
        SCAN_ISSUE,
        SCAN_WAIT,
        HALT,
        ERROR
    } state_t;

    localparam logic [7:0]             OPEN_BR   = 8'h5B;
    localparam logic [7:0]             CLOSE_BR  = 8'h5D;
    localparam logic [ADDR_WIDTH-1:0]  PC_MAX    = '1;
    localparam logic [ADDR_WIDTH-1:0]  PC_ZERO   = '0;
    localparam logic [ADDR_WIDTH-1:0]  PC_ONE    = ADDR_WIDTH'(1);
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_MAX = '1;
    localparam logic [DEPTH_WIDTH-1:0] DEPTH_ONE = DEPTH_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic [ADDR_WIDTH-1:0]  pc_reg, pc_next;
    logic [DEPTH_WIDTH-1:0] depth_reg, depth_next;
    logic                   fwd_reg, fwd_next;
    logic [7:0]             instr_reg, instr_next;

    logic accept;
    logic scan_inc;
    logic scan_dec;

    assign accept = (state_reg == VALID) && bus.instrReady;

    // During a scan, the bracket that opens a nesting level depends on direction
    assign scan_inc = fwd_reg ? (bus.romData == OPEN_BR)  : (bus.romData == CLOSE_BR);
    assign scan_dec = fwd_reg ? (bus.romData == CLOSE_BR) : (bus.romData == OPEN_BR);

`ifdef BF_FETCH_COMMENT_SKIP_EN
    logic is_cmd;
    // Recognise the eight brainfuck command characters
    always_comb begin
        case (bus.romData)
            8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D: is_cmd = 1'b1;
            default:                                                is_cmd = 1'b0;
        endcase
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ISSUE;
            pc_reg    <= '0;
            depth_reg <= '0;
            fwd_reg   <= 1'b0;
            instr_reg <= 8'h00;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            depth_reg <= depth_next;
            fwd_reg   <= fwd_next;
            instr_reg <= instr_next;
        end
    end

    // Next-state logic: fetch, handshake, bracket scan and terminal states
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        depth_next = depth_reg;
        fwd_next   = fwd_reg;
        instr_next = instr_reg;

        case (state_reg)
            ISSUE: begin
                state_next = WAIT;
            end

            WAIT: begin
                if (bus.romData == 8'h00) begin
                    state_next = HALT;
`ifdef BF_FETCH_COMMENT_SKIP_EN
                end else if (!is_cmd) begin
                    if (pc_reg == PC_MAX) begin
                        state_next = HALT;
                    end else begin
                        pc_next    = pc_reg + PC_ONE;
                        state_next = ISSUE;
                    end
`endif
                end else begin
                    instr_next = bus.romData;
                    state_next = VALID;
                end
            end

            VALID: begin
                if (accept) begin
                    if (instr_reg == OPEN_BR && bus.cellZero) begin
                        // Nothing lies beyond the last address to match against
                        if (pc_reg == PC_MAX) begin
                            state_next = ERROR;
                        end else begin
                            depth_next = DEPTH_ONE;
                            fwd_next   = 1'b1;
                            pc_next    = pc_reg + PC_ONE;
                            state_next = SCAN_ISSUE;
                        end
                    end else if (instr_reg == CLOSE_BR && !bus.cellZero) begin
                        if (pc_reg == PC_ZERO) begin
                            state_next = ERROR;
                        end else begin
                            depth_next = DEPTH_ONE;
                            fwd_next   = 1'b0;
                            pc_next    = pc_reg - PC_ONE;
                            state_next = SCAN_ISSUE;
                        end
                    end else if (pc_reg == PC_MAX) begin
                        state_next = HALT;
                    end else begin
                        pc_next    = pc_reg + PC_ONE;
                        state_next = ISSUE;
                    end
                end
            end

            SCAN_ISSUE: begin
                state_next = SCAN_WAIT;
            end

            SCAN_WAIT: begin
                if (bus.romData == 8'h00) begin
                    state_next = ERROR;
                end else if (scan_inc && depth_reg == DEPTH_MAX) begin
                    state_next = ERROR;
                end else if (scan_dec && depth_reg == DEPTH_ONE) begin
                    // Match found: resume just past the matching bracket
                    depth_next = '0;
                    if (pc_reg == PC_MAX) begin
                        state_next = HALT;
                    end else begin
                        pc_next    = pc_reg + PC_ONE;
                        state_next = ISSUE;
                    end
                end else begin
                    if (scan_inc) begin
                        depth_next = depth_reg + DEPTH_ONE;
                    end else if (scan_dec) begin
                        depth_next = depth_reg - DEPTH_ONE;
                    end
                    if (fwd_reg) begin
                        if (pc_reg == PC_MAX) begin
                            state_next = ERROR;
                        end else begin
                            pc_next    = pc_reg + PC_ONE;
                            state_next = SCAN_ISSUE;
                        end
                    end else begin
                        if (pc_reg == PC_ZERO) begin
                            state_next = ERROR;
                        end else begin
                            pc_next    = pc_reg - PC_ONE;
                            state_next = SCAN_ISSUE;
                        end
                    end
                end
            end

            HALT: begin
                state_next = HALT;
            end

            ERROR: begin
                state_next = ERROR;
            end

            default: begin
                state_next = ERROR;
            end
        endcase
    end

    assign bus.romAddr    = pc_reg;
    assign bus.instr      = instr_reg;
    assign bus.instrValid = (state_reg == VALID);
    assign bus.halted     = (state_reg == HALT);
    assign bus.error      = (state_reg == ERROR);

endmodule

// File: tb/tb_bf_fetch_unit.sv
// Testbench for bf_fetch_unit: registered-output ROM model, table of expected
// presented instructions (address, byte, latency) fed through a scoreboard
// queue, plus hand-written backpressure and reset-during-scan sequences.
module tb_bf_fetch_unit;
    logic clk;
    logic reset;

    bf_fetch_if #(.ADDR_WIDTH(4)) bus ();

    bf_fetch_unit #(.ADDR_WIDTH(4), .DEPTH_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] rom [16];

    // Program ROM with one-clock registered read
    always @(posedge clk) bus.romData <= rom[bus.romAddr];

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
        logic       cz;
        logic [3:0] lat;
        logic [3:0] hold;
    } vec_t;

    vec_t tbl [40];
    int   ntbl;
    vec_t sb_q [$];

    int checks;
    int failures;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] a, input logic [7:0] d, input logic cz,
                       input logic [3:0] lat, input logic [3:0] hold);
        tbl[ntbl] = '{addr: a, data: d, cz: cz, lat: lat, hold: hold};
        ntbl++;
    endtask

    task automatic load_rom1();
        logic [7:0] p [11];
        p = '{8'h2B, 8'h5B, 8'h2E, 8'h2B, 8'h5D, 8'h3E, 8'h2C, 8'h5B, 8'h2E, 8'h2D, 8'h5D};
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        for (int i = 0; i < 11; i++) rom[i] = p[i];
    endtask

    task automatic load_rom2();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0] = 8'h5B; rom[1] = 8'h5B; rom[2] = 8'h2E; rom[3] = 8'h5D;
    endtask

    // Hold reset 3 cycles, check reset outputs, release at a falling edge
    task automatic do_reset();
        reset = 1'b1;
        bus.instrReady = 1'b1;
        bus.cellZero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_romAddr", 32'(bus.romAddr), 32'd0);
        chk("rst_valid", 32'(bus.instrValid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_error", 32'(bus.error), 32'd0);
        reset = 1'b0;
    endtask

    // Wait for the next presented instruction, compare, optionally stall, accept
    task automatic expect_instr(input vec_t v);
        int n;
        logic [7:0] held;
        n = 0;
        while (!bus.instrValid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.instrValid) begin
            chk("valid_timeout", 32'(bus.instrValid), 32'd1);
            return;
        end
        $display("txn addr=%0d instr=%02h lat=%0d exp_addr=%0d exp_instr=%02h exp_lat=%0d",
                 bus.romAddr, bus.instr, n, v.addr, v.data, v.lat);
        chk("latency", 32'(n), 32'(v.lat));
        chk("instr", 32'(bus.instr), 32'(v.data));
        chk("addr", 32'(bus.romAddr), 32'(v.addr));
        if (v.hold != 0) begin
            held = bus.instr;
            bus.instrReady = 1'b0;
            bus.cellZero = ~v.cz;
            repeat (v.hold) @(negedge clk);
            chk("hold_instr", 32'(bus.instr), 32'(held));
            chk("hold_valid", 32'(bus.instrValid), 32'd1);
            chk("hold_addr", 32'(bus.romAddr), 32'(v.addr));
            bus.instrReady = 1'b1;
        end
        bus.cellZero = v.cz;
        @(posedge clk);
        @(negedge clk);
        bus.cellZero = ~v.cz;
    endtask

    // Wait for the terminal state and check it is sticky with pc frozen
    task automatic expect_end(input logic is_err, input logic [3:0] addr);
        int n;
        n = 0;
        while (!(bus.halted || bus.error) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("end_halted", 32'(bus.halted), 32'(!is_err));
        chk("end_error", 32'(bus.error), 32'(is_err));
        chk("end_addr", 32'(bus.romAddr), 32'(addr));
        chk("end_valid", 32'(bus.instrValid), 32'd0);
        repeat (5) @(negedge clk);
        chk("sticky_addr", 32'(bus.romAddr), 32'(addr));
        chk("sticky_flag", 32'(is_err ? bus.error : bus.halted), 32'd1);
        chk("sticky_valid", 32'(bus.instrValid), 32'd0);
        $display("txn end halted=%0d error=%0d addr=%0d", bus.halted, bus.error, bus.romAddr);
    endtask

    task automatic run(input int first, input int last, input logic is_err, input logic [3:0] addr);
        vec_t v;
        do_reset();
        for (int i = first; i <= last; i++) sb_q.push_back(tbl[i]);
        while (sb_q.size() > 0) begin
            v = sb_q.pop_front();
            expect_instr(v);
        end
        expect_end(is_err, addr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, r1, r2, r3;
        checks = 0;
        failures = 0;
        ntbl = 0;
        reset = 1'b1;
        bus.instrReady = 1'b1;
        bus.cellZero = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;

        // Run 0: all brackets fall through, stall 10 cycles at addr 2
        r0 = ntbl;
        add(0, 8'h2B, 1, 2, 0);
        add(1, 8'h5B, 0, 2, 0);
        add(2, 8'h2E, 1, 2, 10);
        add(3, 8'h2B, 0, 2, 0);
        add(4, 8'h5D, 1, 2, 0);
        add(5, 8'h3E, 0, 2, 0);
        add(6, 8'h2C, 1, 2, 0);
        add(7, 8'h5B, 0, 2, 0);
        add(8, 8'h2E, 1, 2, 0);
        add(9, 8'h2D, 0, 2, 0);
        add(10, 8'h5D, 1, 2, 0);
        // Run 1: forward jump at 1, backward jump at 10 back to 8
        r1 = ntbl;
        add(0, 8'h2B, 0, 2, 0);
        add(1, 8'h5B, 1, 2, 0);
        add(5, 8'h3E, 0, 8, 0);
        add(6, 8'h2C, 1, 2, 0);
        add(7, 8'h5B, 0, 2, 0);
        add(8, 8'h2E, 0, 2, 0);
        add(9, 8'h2D, 0, 2, 0);
        add(10, 8'h5D, 0, 2, 0);
        add(8, 8'h2E, 0, 8, 0);
        add(9, 8'h2D, 0, 2, 0);
        add(10, 8'h5D, 1, 2, 0);
        // Run 2: backward jump at 4 to 2, forward jump at 7 lands on program end
        r2 = ntbl;
        add(0, 8'h2B, 0, 2, 0);
        add(1, 8'h5B, 0, 2, 0);
        add(2, 8'h2E, 0, 2, 0);
        add(3, 8'h2B, 0, 2, 0);
        add(4, 8'h5D, 0, 2, 0);
        add(2, 8'h2E, 1, 8, 0);
        add(3, 8'h2B, 1, 2, 0);
        add(4, 8'h5D, 1, 2, 0);
        add(5, 8'h3E, 0, 2, 0);
        add(6, 8'h2C, 0, 2, 0);
        add(7, 8'h5B, 1, 2, 0);
        // Run 3: nested scan hits 0x00 before matching
        r3 = ntbl;
        add(0, 8'h5B, 1, 2, 0);

        load_rom1();
        run(r0, r1 - 1, 1'b0, 4'd11);
        run(r1, r2 - 1, 1'b0, 4'd11);
        run(r2, r3 - 1, 1'b0, 4'd11);
        load_rom2();
        run(r3, r3, 1'b1, 4'd4);

        // Reset in the middle of a forward scan, then restart cleanly
        load_rom1();
        do_reset();
        expect_instr('{addr: 4'd0, data: 8'h2B, cz: 1'b0, lat: 4'd2, hold: 4'd0});
        expect_instr('{addr: 4'd1, data: 8'h5B, cz: 1'b1, lat: 4'd2, hold: 4'd0});
        repeat (3) @(negedge clk);
        chk("mid_scan_valid", 32'(bus.instrValid), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("scan_rst_addr", 32'(bus.romAddr), 32'd0);
        chk("scan_rst_error", 32'(bus.error), 32'd0);
        chk("scan_rst_valid", 32'(bus.instrValid), 32'd0);
        reset = 1'b0;
        $display("txn reset during forward scan");
        expect_instr('{addr: 4'd0, data: 8'h2B, cz: 1'b1, lat: 4'd2, hold: 4'd0});
        expect_instr('{addr: 4'd1, data: 8'h5B, cz: 1'b0, lat: 4'd2, hold: 4'd0});
        expect_instr('{addr: 4'd2, data: 8'h2E, cz: 1'b0, lat: 4'd2, hold: 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bf_fetch_unit.md
Name: bf_fetch_unit

Overview:
- Instruction fetch and jump unit for the brainfuck core.
- Reads program bytes from the registered-output program ROM (4-bit address in, 8-bit data out, one-clock read latency) and presents one instruction at a time to the execute stage over a valid/ready handshake.
- Resolves '[' / ']' jumps by scanning the ROM with a nesting-depth counter.
- Signals program end (0x00 byte) and unmatched brackets.

Parameters:
ADDR_WIDTH, 4, program counter / ROM address width
DEPTH_WIDTH, 8, bracket nesting counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous active-high reset
romAddr  out  ADDR_WIDTH  address to program ROM, equals pc register
romData  in  8  ROM data; valid the cycle after romAddr is sampled
instr  out  8  current instruction byte
instrValid  out  1  instr is valid
instrReady  in  1  core accepts instr on clk edge when instrValid=1
cellZero  in  1  current data cell == 0; sampled only on accept
halted  out  1  program end reached (sticky)
error  out  1  unmatched bracket or depth overflow (sticky)

Behaviour:
- Reset values (reset sampled high): pc=0, state=ISSUE, instr=0x00, instrValid=0, halted=0, error=0, depth=0. Reset overrides every state, including mid-scan.
- States: ISSUE, WAIT, VALID, SCAN_ISSUE, SCAN_WAIT, HALT, ERROR.
- ISSUE: romAddr=pc; ROM samples at the end of the cycle; next state WAIT.
- WAIT, end of cycle:
  - romData==0x00 -> HALT.
  - Otherwise instr<=romData, instrValid<=1 -> VALID.
- VALID: instr holds stable until accept. Accept = instrValid & instrReady at an edge. On accept, instrValid<=0 and:
  - '[' (0x5B) with cellZero=1: depth<=1, pc<=pc+1, -> SCAN_ISSUE with direction forward.
  - ']' (0x5D) with cellZero=0: depth<=1, pc<=pc-1, -> SCAN_ISSUE with direction backward.
  - Any other byte, or a bracket whose condition fails: pc<=pc+1 -> ISSUE.
  - If pc==max (all ones) and the next pc would wrap to 0: -> HALT instead.
- Timing:
  - First instrValid rises after the 2nd edge with reset low.
  - Non-jump throughput: one instruction per 3 cycles (VALID -> ISSUE -> WAIT -> VALID) with instrReady tied high.
- Scan: 2 cycles per scanned byte (SCAN_ISSUE, SCAN_WAIT). Byte is evaluated at the end of SCAN_WAIT.
  - Forward: '[' depth+1, ']' depth-1.
  - Backward: ']' depth+1, '[' depth-1.
  - Depth reaches 0: pc<=matching address+1 -> ISSUE.
  - Otherwise pc steps one position in the scan direction -> SCAN_ISSUE.
- Scan error conditions (-> ERROR):
  - 0x00 byte during either scan.
  - Forward scan at pc==max without a match.
  - Backward scan at pc==0 without a match.
  - depth increment at all-ones.
- HALT: halted=1, instrValid=0, pc frozen; exits only on reset.
- ERROR: error=1, instrValid=0, pc frozen at the failing address; exits only on reset. halted and error are never both 1.
- instrReady while instrValid=0 is ignored. cellZero is ignored outside accept.

Optional Feature:
- Macro: BF_FETCH_COMMENT_SKIP_EN.
- Defined: in WAIT, any byte other than + - < > . , [ ] and 0x00 is not presented. pc<=pc+1 -> ISSUE, 2 cycles per skipped byte, with the same wrap-to-HALT rule. Scan treats these bytes as non-bracket bytes, same as without the macro.
- Undefined: every non-zero byte is presented to the core, which executes non-commands as no-ops.

Test Plan:
- ROM "+[.+]>,[.-]" (0x2B,0x5B,0x2E,0x2B,0x5D,0x3E,0x2C,0x5B,0x2E,0x2D,0x5D, then 0x00), reset 3 cycles then release, instrReady=1 -> romAddr=0 during reset; instr=0x2B, instrValid=1 after 2nd edge; then 0x5B 3 cycles later.
- Same ROM, accept '[' at addr 1 with cellZero=1 -> scans addrs 2,3,4 (6 cycles); next presented instr=0x3E from addr 5.
- Same ROM, accept ']' at addr 4 with cellZero=0 -> backward scan addrs 3,2,1; next presented instr=0x2E from addr 2.
- Same ROM, all brackets fall through (cellZero=1 at ']', cellZero=0 at '[') -> instrs addr 0..10 presented in order, then halted=1 at addr 11, instrValid stays 0.
- ROM "[[.]" then 0x00, accept addr 0 '[' with cellZero=1 -> depth reaches 2, then 1, then 0x00 at addr 4 -> error=1, romAddr=4, halted=0.
- Backpressure and reset: hold instrReady=0 for 10 cycles at addr 2 -> instr=0x2E stable, pc unchanged. Separately, assert reset during forward scan -> next instr=0x2B from addr 0, error=0, depth=0.
